// File: rtl/mask_expander_pkg.sv
// Shared definitions for the mask expander and the prefix-sum compaction logic:
// lane count, FSM encodings, non-zero count width and the prefix-sum adder.
package mask_expander_pkg;

  localparam int MASK_LANES = 32;
  localparam int NNZ_W      = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2
  } state_t;

  // Running prefix sum over the mask; the top output is the total popcount.
  function automatic logic [NNZ_W-1:0] prefix_sum_top(input logic [MASK_LANES-1:0] v);
    logic [NNZ_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < MASK_LANES; i++) begin
      acc = acc + {{(NNZ_W-1){1'b0}}, v[i]};
    end
    return acc;
  endfunction

endpackage

// File: rtl/lsb_finder32.sv
// Combinational search for the lowest set bit of a 32-bit vector.
module lsb_finder32 (
  input  logic [31:0] vec,
  output logic [4:0]  idx,
  output logic        found
);

  // Scan downwards so the lowest set bit is the last one to win.
  always_comb begin
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
  end

  assign found = |vec;

endmodule

// File: rtl/mask_expander.sv
// Expands a stream of compacted elements into a full lane vector under a mask,
// filling lanes in ascending order, one element per cycle.
module mask_expander
  import mask_expander_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mask_valid,
  input  logic [LANES-1:0]        mask,
  output logic                    mask_ready,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [LANES*DATA_W-1:0] out_vec,
  output logic [NNZ_W-1:0]        out_nnz,
  input  logic                    out_ready
);

  state_t            state_reg;
  logic [LANES-1:0]  rem_mask_reg;
  logic [LANES-1:0]  rem_mask_next;
  logic [DATA_W-1:0] lane_reg [LANES];
  logic [NNZ_W-1:0]  nnz_reg;
  logic              mask_ready_reg;
  logic              in_ready_reg;
  logic              out_valid_reg;
  logic [4:0]        lsb_idx;
  logic              lsb_found;

  lsb_finder32 u_lsb_finder (
    .vec   (rem_mask_reg),
    .idx   (lsb_idx),
    .found (lsb_found)
  );

  always_comb begin
    rem_mask_next = rem_mask_reg;
    rem_mask_next[lsb_idx] = 1'b0;
  end

  // Ready/valid flags are registered alongside the state, so they never
  // depend combinationally on in_valid or out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      rem_mask_reg   <= '0;
      nnz_reg        <= '0;
      mask_ready_reg <= 1'b1;
      in_ready_reg   <= 1'b0;
      out_valid_reg  <= 1'b0;
      for (int i = 0; i < LANES; i++) lane_reg[i] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (mask_valid) begin
            rem_mask_reg   <= mask;
            nnz_reg        <= prefix_sum_top(mask);
            mask_ready_reg <= 1'b0;
            for (int i = 0; i < LANES; i++) lane_reg[i] <= '0;
            if (mask != '0) begin
              state_reg    <= FILL;
              in_ready_reg <= 1'b1;
            end else begin
              state_reg     <= EMIT;
              out_valid_reg <= 1'b1;
            end
          end
        end
        FILL: begin
          if (in_valid && lsb_found) begin
            lane_reg[lsb_idx] <= in_data;
            rem_mask_reg      <= rem_mask_next;
            if (rem_mask_next == '0) begin
              state_reg     <= EMIT;
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            state_reg      <= IDLE;
            out_valid_reg  <= 1'b0;
            mask_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg      <= IDLE;
          mask_ready_reg <= 1'b1;
          in_ready_reg   <= 1'b0;
          out_valid_reg  <= 1'b0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign out_vec[gi*DATA_W +: DATA_W] = lane_reg[gi];
    end
  endgenerate

  assign mask_ready = mask_ready_reg;
  assign in_ready   = in_ready_reg;
  assign out_valid  = out_valid_reg;
  assign out_nnz    = nnz_reg;

endmodule

// File: tb/tb_mask_expander.sv
// Directed bench for mask_expander: reset, sparse/empty/full masks,
// backpressure, reset mid-fill and back-to-back vectors.
module tb_mask_expander;

  logic          clk = 1'b0;
  logic          reset;
  logic          mask_valid;
  logic [31:0]   mask;
  logic          mask_ready;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_ready;
  logic          out_valid;
  logic [1023:0] out_vec;
  logic [5:0]    out_nnz;
  logic          out_ready;

  int checks = 0;
  int errors = 0;
  logic [1023:0] exp_vec;

  mask_expander #(.DATA_W(32), .LANES(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .mask_valid (mask_valid),
    .mask       (mask),
    .mask_ready (mask_ready),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_vec    (out_vec),
    .out_nnz    (out_nnz),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mask_valid = 1'b1; mask = 32'hFFFF_FFFF;
    in_valid = 1'b1; in_data = 32'h1234; out_ready = 1'b0;
    tick(); tick();
    checks++; if (mask_ready !== 1'b1) begin errors++; $display("FAIL reset_mask_ready: got %b expected 1", mask_ready); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_vec !== '0) begin errors++; $display("FAIL reset_out_vec: got %h expected 0", out_vec); end
    checks++; if (out_nnz !== 6'd0) begin errors++; $display("FAIL reset_out_nnz: got %0d expected 0", out_nnz); end
    reset = 1'b0; mask_valid = 1'b0; mask = '0; in_valid = 1'b0;
    tick();
    $display("reset: done");
  endtask

  task automatic test_sparse();
    mask = 32'b00001000000010000010000000010011;
    mask_valid = 1'b1;
    tick();
    mask_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sparse_fill_entry: in_ready got %b expected 1", in_ready); end
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sparse_early_valid: at element %0d got %b expected 0", k, out_valid); end
      in_data = 32'hA1 + k;
      tick();
    end
    in_valid = 1'b0;
    exp_vec = '0;
    exp_vec[0*32 +: 32]  = 32'hA1;
    exp_vec[1*32 +: 32]  = 32'hA2;
    exp_vec[4*32 +: 32]  = 32'hA3;
    exp_vec[13*32 +: 32] = 32'hA4;
    exp_vec[19*32 +: 32] = 32'hA5;
    exp_vec[27*32 +: 32] = 32'hA6;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sparse_latency: out_valid got %b expected 1 at 7 cycles", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sparse_emit_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_vec !== exp_vec) begin errors++; $display("FAIL sparse_vec: got %h expected %h", out_vec, exp_vec); end
    checks++; if (out_nnz !== 6'd6) begin errors++; $display("FAIL sparse_nnz: got %0d expected 6", out_nnz); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (mask_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL sparse_return_idle: mask_ready %b out_valid %b expected 1 0", mask_ready, out_valid); end
    $display("sparse: vector emitted nnz=%0d", 6);
  endtask

  task automatic test_empty();
    mask = 32'h0;
    mask_valid = 1'b1;
    tick();
    mask_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL empty_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL empty_out_valid: got %b expected 1", out_valid); end
    checks++; if (out_vec !== '0) begin errors++; $display("FAIL empty_vec: got %h expected 0", out_vec); end
    checks++; if (out_nnz !== 6'd0) begin errors++; $display("FAIL empty_nnz: got %0d expected 0", out_nnz); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    $display("empty: vector emitted nnz=0");
  endtask

  task automatic test_full_gaps();
    int accepted;
    int cyc;
    logic take;
    accepted = 0;
    cyc = 0;
    mask = 32'hFFFF_FFFF;
    mask_valid = 1'b1;
    tick();
    mask_valid = 1'b0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      in_valid = (cyc % 2 == 0);
      in_data = 32'(accepted + 1);
      take = in_valid && in_ready;
      tick();
      if (take) accepted++;
      cyc++;
    end
    in_valid = 1'b0;
    exp_vec = '0;
    for (int i = 0; i < 32; i++) exp_vec[i*32 +: 32] = 32'(i + 1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_timeout: out_valid got %b expected 1 within 200 cycles", out_valid); end
    checks++; if (accepted != 32) begin errors++; $display("FAIL full_handshakes: got %0d expected 32", accepted); end
    checks++; if (out_vec !== exp_vec) begin errors++; $display("FAIL full_vec: got %h expected %h", out_vec, exp_vec); end
    checks++; if (out_nnz !== 6'd32) begin errors++; $display("FAIL full_nnz: got %0d expected 32", out_nnz); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    $display("full: vector emitted after %0d handshakes", accepted);
  endtask

  task automatic test_backpressure();
    mask = 32'h0000_0005;
    mask_valid = 1'b1;
    tick();
    mask_valid = 1'b0;
    in_valid = 1'b1; in_data = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    in_valid = 1'b0;
    exp_vec = '0;
    exp_vec[0*32 +: 32] = 32'h11;
    exp_vec[2*32 +: 32] = 32'h22;
    for (int c = 0; c < 5; c++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold: cycle %0d got %b expected 1", c, out_valid); end
      checks++; if (out_vec !== exp_vec) begin errors++; $display("FAIL bp_vec_hold: cycle %0d got %h expected %h", c, out_vec, exp_vec); end
      checks++; if (mask_ready !== 1'b0) begin errors++; $display("FAIL bp_mask_ready: cycle %0d got %b expected 0", c, mask_ready); end
      tick();
    end
    checks++; if (out_nnz !== 6'd2) begin errors++; $display("FAIL bp_nnz: got %0d expected 2", out_nnz); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (mask_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_idle: mask_ready %b out_valid %b expected 1 0", mask_ready, out_valid); end
    $display("backpressure: vector emitted after 5 stall cycles");
  endtask

  task automatic test_reset_mid_fill();
    mask = 32'h0000_000F;
    mask_valid = 1'b1;
    tick();
    mask_valid = 1'b0;
    in_valid = 1'b1; in_data = 32'hB1;
    tick();
    in_data = 32'hB2;
    tick();
    reset = 1'b1; in_data = 32'hB3;
    tick();
    reset = 1'b0;
    checks++; if (mask_ready !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_fill_idle: mask_ready %b in_ready %b expected 1 0", mask_ready, in_ready); end
    checks++; if (out_vec !== '0) begin errors++; $display("FAIL rst_fill_vec: got %h expected 0", out_vec); end
    checks++; if (out_nnz !== 6'd0) begin errors++; $display("FAIL rst_fill_nnz: got %0d expected 0", out_nnz); end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_fill_no_valid: cycle %0d got %b expected 0", c, out_valid); end
    end
    in_valid = 1'b0;
    $display("reset_mid_fill: partial vector discarded");
  endtask

  task automatic test_back_to_back();
    mask = 32'h0000_0001; mask_valid = 1'b1;
    in_valid = 1'b1; in_data = 32'h55;
    out_ready = 1'b1;
    tick();
    mask = 32'h8000_0000;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_fill1: in_ready got %b expected 1", in_ready); end
    tick();
    exp_vec = '0;
    exp_vec[0*32 +: 32] = 32'h55;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1: got %b expected 1", out_valid); end
    checks++; if (out_vec !== exp_vec) begin errors++; $display("FAIL b2b_vec1: got %h expected %h", out_vec, exp_vec); end
    $display("back_to_back: vector 1 emitted lane 0");
    in_data = 32'h66;
    tick();
    checks++; if (mask_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap: mask_ready %b out_valid %b expected 1 0", mask_ready, out_valid); end
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_fill2: in_ready got %b expected 1", in_ready); end
    tick();
    mask_valid = 1'b0; in_valid = 1'b0;
    exp_vec = '0;
    exp_vec[31*32 +: 32] = 32'h66;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid2: got %b expected 1", out_valid); end
    checks++; if (out_vec !== exp_vec) begin errors++; $display("FAIL b2b_vec2: got %h expected %h", out_vec, exp_vec); end
    checks++; if (out_nnz !== 6'd1) begin errors++; $display("FAIL b2b_nnz2: got %0d expected 1", out_nnz); end
    $display("back_to_back: vector 2 emitted lane 31");
    tick();
    out_ready = 1'b0;
    checks++; if (mask_ready !== 1'b1) begin errors++; $display("FAIL b2b_final_idle: mask_ready got %b expected 1", mask_ready); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mask_valid = 1'b0; mask = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_sparse();
    test_empty();
    test_full_gaps();
    test_backpressure();
    test_reset_mid_fill();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mask_expander.md
MASK_EXPANDER -- requirements
Module: mask_expander

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the element width in bits.
REQ-002 SHALL have parameter LANES, default 32, giving the mask width and output vector lane count; only 32 is supported.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mask_valid  input  1  mask offered.
REQ-006 SHALL have port mask  input  LANES  lane-occupancy mask; bit i set means lane i receives a compacted element.
REQ-007 SHALL have port mask_ready  output  1  mask accepted this cycle when high together with mask_valid.
REQ-008 SHALL have port in_valid  input  1  compacted element offered.
REQ-009 SHALL have port in_data  input  DATA_W  compacted element, in ascending lane order.
REQ-010 SHALL have port in_ready  output  1  element accepted when high together with in_valid.
REQ-011 SHALL have port out_valid  output  1  expanded vector available.
REQ-012 SHALL have port out_vec  output  LANES*DATA_W  expanded vector; lane i is bits [i*DATA_W +: DATA_W].
REQ-013 SHALL have port out_nnz  output  6  popcount of the mask that built out_vec.
REQ-014 SHALL have port out_ready  input  1  consumer accepts out_vec.

Function
REQ-015 SHALL implement FSM states IDLE, FILL and EMIT.
REQ-016 IDLE SHALL assert mask_ready=1, in_ready=0 and out_valid=0.
REQ-017 On a mask handshake, the block SHALL latch mask into rem_mask, clear all out_vec lanes to 0, and latch popcount(mask) into out_nnz.
REQ-018 After that mask handshake, the FSM SHALL go to FILL if mask!=0 and to EMIT if mask==0.
REQ-019 FILL SHALL assert in_ready=1, mask_ready=0 and out_valid=0.
REQ-020 On each FILL handshake, in_data SHALL be written to lane p, where p is the index of the lowest set bit of rem_mask.
REQ-021 On each FILL handshake, bit p of rem_mask SHALL be cleared in the same cycle.
REQ-022 The FILL handshake that clears the last set bit SHALL move the FSM to EMIT on the next edge.
REQ-023 A FILL cycle with in_valid=0 SHALL change no state.
REQ-024 EMIT SHALL assert out_valid=1, with out_vec and out_nnz stable, and in_ready=0, mask_ready=0.
REQ-025 In EMIT, out_valid SHALL hold under backpressure (out_ready=0) indefinitely.
REQ-026 An EMIT cycle with out_ready=1 SHALL return the FSM to IDLE; the next mask handshake occurs no earlier than the following cycle.
REQ-027 Masked-off lanes SHALL read 0 in out_vec.
REQ-028 Latency from mask handshake to out_valid SHALL be N+1 cycles minimum, where N=popcount(mask), one element per cycle; it SHALL be 1 cycle when N=0.
REQ-029 N=32 (all-ones mask) SHALL take exactly 32 accepted elements, with no counter overflow; out_nnz=32.
REQ-030 Input ready signals SHALL depend only on the FSM state, with no combinational path from out_ready or in_valid.
REQ-031 Throughput SHALL be one vector per N+2 cycles with no stalls.

Reset
REQ-032 While reset=1 at a clock edge, state SHALL be IDLE, rem_mask=0, out_vec=0 and out_nnz=0.
REQ-033 While reset=1 at a clock edge, mask_ready=1, in_ready=0 and out_valid=0 from the next cycle.
REQ-034 Reset asserted mid-FILL or mid-EMIT SHALL discard the partial vector; no out_valid SHALL follow.
REQ-035 Handshakes SHALL be ignored in any cycle where reset=1.

Structure
REQ-036 LANES, the state encodings (IDLE=2'd0, FILL=2'd1, EMIT=2'd2) and the out_nnz width SHALL reside in a shared include header used by this block and the prefix-sum compaction logic.
REQ-037 The lowest-set-bit search SHALL be a separate combinational sub-module, lsb_finder32, with input vec[31:0] and outputs idx[4:0] and found.
REQ-038 Popcount SHALL reuse the existing 32-bit prefix-sum adder's top output, not a new adder.

Verification
REQ-039 Sparse mask: mask=32'b00001000000010000010000000010011, in_data 0xA1..0xA6 back-to-back -> lanes 0,1,4,13,19,27 = 0xA1..0xA6; all other lanes 0; out_nnz=6; out_valid exactly 7 cycles after the mask handshake.
REQ-040 Empty mask: mask=0 -> in_ready never asserts; out_valid in the next cycle; out_vec=0; out_nnz=0.
REQ-041 Full mask with input gaps: mask=32'hFFFFFFFF, elements i+1 for i=0..31, in_valid toggled 1/0 -> lane i=i+1; out_nnz=32; exactly 32 handshakes accepted.
REQ-042 Backpressure: hold out_ready=0 for 5 cycles in EMIT -> out_valid and out_vec stable; mask_ready=0 throughout; IDLE the cycle after out_ready=1.
REQ-043 Reset mid-FILL: mask=32'h0000000F, two elements accepted, then reset=1 for 1 cycle -> IDLE; out_vec=0; no out_valid.
REQ-044 Back-to-back vectors: two masks 32'h1 then 32'h80000000 with continuous valid -> lane 0 then lane 31 populated; vectors never merged; a 1-cycle IDLE gap between them.
